// File: rtl/fetch_pc_predictor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_predictor_pkg
// Description : Shared definitions for the fetch PC predictor: BTB 2-bit
//               counter state codes, default BTB size and the counter
//               step function.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pc_predictor_pkg;

    // 2-bit branch counter codes; bit 1 set means "predict taken".
    typedef enum logic [1:0] {
        STRONG_NOT_TAKEN = 2'b00,
        WEAK_NOT_TAKEN   = 2'b01,
        STRONG_TAKEN     = 2'b10,
        WEAK_TAKEN       = 2'b11
    } btb_state_t;

    localparam int BTB_ENTRIES_DEFAULT = 16;

    // Saturating step: SNT <-> WNT <-> WT <-> ST.
    function automatic btb_state_t btb_next_state(input btb_state_t cur, input logic taken);
        btb_state_t nxt;
        nxt = cur;
        case (cur)
            STRONG_NOT_TAKEN: nxt = taken ? WEAK_NOT_TAKEN   : STRONG_NOT_TAKEN;
            WEAK_NOT_TAKEN:   nxt = taken ? WEAK_TAKEN       : STRONG_NOT_TAKEN;
            WEAK_TAKEN:       nxt = taken ? STRONG_TAKEN     : WEAK_NOT_TAKEN;
            STRONG_TAKEN:     nxt = taken ? STRONG_TAKEN     : WEAK_TAKEN;
            default:          nxt = STRONG_NOT_TAKEN;
        endcase
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_pc_predictor_btb_table.sv
`default_nettype none
// ============================================================================
// Module      : btb_table
// Description : Direct-mapped branch target buffer. Combinational lookup of
//               lookup_pc; one update per cycle from the EX stage.
// Ports       : clk, rst_n        - clock, async active-low reset
//               lookup_pc         - PC to predict for
//               lookup_taken/target - prediction (taken = hit && state[1])
//               upd_en/pc/taken/target - resolved control-flow update
// Revision    : 1.0 - initial release
// ============================================================================
module btb_table
    import fetch_pc_predictor_pkg::*;
#(
    parameter int BTB_ENTRIES = BTB_ENTRIES_DEFAULT,
    parameter int IDX_W       = $clog2(BTB_ENTRIES)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] lookup_pc,
    output logic        lookup_taken,
    output logic [31:0] lookup_target,
    input  logic        upd_en,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target
);

    localparam int TAG_W = 32 - IDX_W - 2;

    logic                r_valid  [BTB_ENTRIES];
    logic [TAG_W-1:0]    r_tag    [BTB_ENTRIES];
    logic [31:0]         r_target [BTB_ENTRIES];
    btb_state_t          r_state  [BTB_ENTRIES];

    logic [IDX_W-1:0]    w_lkp_idx;
    logic [TAG_W-1:0]    w_lkp_tag;
    logic                w_lkp_hit;
    logic [IDX_W-1:0]    w_upd_idx;
    logic [TAG_W-1:0]    w_upd_tag;
    logic                w_upd_hit;
    logic [3:0]          w_unused_lsbs;

    assign w_lkp_idx = lookup_pc[IDX_W+1:2];
    assign w_lkp_tag = lookup_pc[31:IDX_W+2];
    assign w_upd_idx = upd_pc[IDX_W+1:2];
    assign w_upd_tag = upd_pc[31:IDX_W+2];
    assign w_unused_lsbs = {lookup_pc[1:0], upd_pc[1:0]};

    // Lookup reads the flops, so a same-cycle update is seen one cycle later.
    assign w_lkp_hit     = r_valid[w_lkp_idx] && (r_tag[w_lkp_idx] == w_lkp_tag);
    assign lookup_taken  = w_lkp_hit && r_state[w_lkp_idx][1];
    assign lookup_target = r_target[w_lkp_idx];

    assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_state[i]  <= STRONG_NOT_TAKEN;
            end
        end else if (upd_en) begin
            if (w_upd_hit) begin
                r_state[w_upd_idx] <= btb_next_state(r_state[w_upd_idx], upd_taken);
                if (upd_taken) begin
                    r_target[w_upd_idx] <= upd_target;
                end
            end else if (upd_taken) begin
                // Allocate, evicting whatever alias held this index.
                r_valid[w_upd_idx]  <= 1'b1;
                r_tag[w_upd_idx]    <= w_upd_tag;
                r_target[w_upd_idx] <= upd_target;
                r_state[w_upd_idx]  <= WEAK_TAKEN;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_pc_predictor.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_predictor
// Description : IF-stage next-PC generator: PC register, BTB lookup and
//               EX-stage misprediction resolution / redirect.
// Ports       : clk, rst_n                 - clock, async active-low reset
//               pc_en                      - 0 holds the PC (stall)
//               if_pc/if_pred_taken/if_pred_target - fetch PC and prediction
//               ex_*  inputs               - resolved EX control flow
//               ex_mispredict/ex_redirect_pc - redirect request and target
//               perf_cf_cnt/perf_mispred_cnt - only with BTB_PERF_CNT_EN
// Config      : BTB_PERF_CNT_EN adds the two performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_predictor
    import fetch_pc_predictor_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BTB_ENTRIES = BTB_ENTRIES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_en,
    output logic [31:0] if_pc,
    output logic        if_pred_taken,
    output logic [31:0] if_pred_target,
    input  logic        ex_valid,
    input  logic        ex_is_cf,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        ex_mispredict,
    output logic [31:0] ex_redirect_pc
`ifdef BTB_PERF_CNT_EN
    ,
    output logic [31:0] perf_cf_cnt,
    output logic [31:0] perf_mispred_cnt
`endif
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);

    generate
        if ((BTB_ENTRIES < 2) || ((1 << IDX_W) != BTB_ENTRIES)) begin : g_bad_entries
            $error("BTB_ENTRIES must be a power of 2 and at least 2");
        end
    endgenerate

    logic [31:0] r_pc;
    logic [31:0] w_next_pc;
    logic        w_ex_cf;

    assign w_ex_cf = ex_valid && ex_is_cf;

    assign ex_mispredict  = w_ex_cf &&
                            ((ex_taken != ex_pred_taken) ||
                             (ex_taken && (ex_target != ex_pred_target)));
    assign ex_redirect_pc = ex_taken ? ex_target : (ex_pc + 32'd4);

    // Redirect wins over a stall: the wrong-path instruction must not be held.
    always_comb begin
        w_next_pc = r_pc + 32'd4;
        if (ex_mispredict) begin
            w_next_pc = ex_redirect_pc;
        end else if (!pc_en) begin
            w_next_pc = r_pc;
        end else if (if_pred_taken) begin
            w_next_pc = if_pred_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_next_pc;
        end
    end

    assign if_pc = r_pc;

    btb_table #(
        .BTB_ENTRIES (BTB_ENTRIES),
        .IDX_W       (IDX_W)
    ) u_btb (
        .clk           (clk),
        .rst_n         (rst_n),
        .lookup_pc     (r_pc),
        .lookup_taken  (if_pred_taken),
        .lookup_target (if_pred_target),
        .upd_en        (w_ex_cf),
        .upd_pc        (ex_pc),
        .upd_taken     (ex_taken),
        .upd_target    (ex_target)
    );

`ifdef BTB_PERF_CNT_EN
    logic [31:0] r_perf_cf_cnt;
    logic [31:0] r_perf_mispred_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_cf_cnt      <= '0;
            r_perf_mispred_cnt <= '0;
        end else begin
            if (w_ex_cf) begin
                r_perf_cf_cnt <= r_perf_cf_cnt + 32'd1;
            end
            if (ex_mispredict) begin
                r_perf_mispred_cnt <= r_perf_mispred_cnt + 32'd1;
            end
        end
    end

    assign perf_cf_cnt      = r_perf_cf_cnt;
    assign perf_mispred_cnt = r_perf_mispred_cnt;
`endif

endmodule
`default_nettype wire
